// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types and defaults for the psum reduction scheduler
package psum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PSUM_WIDTH = 19;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and synchronous clear
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_push  = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/psum_reduce_sched.sv
// rtl/psum_reduce_sched.sv - aligns three skewed psum streams and issues credit-limited
// triples to a non-stalling 3-input adder, collecting indexed sums for one output tile.
module psum_reduce_sched
  import psum_pkg::*;
#(
  parameter int WIDTH     = PSUM_WIDTH,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4,
  parameter int NUM_OUT   = 16,
  parameter int IDX_W     = idx_width(NUM_OUT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [2:0]           in_valid_i,
  input  logic [3*WIDTH-1:0]   in_data_i,
  output logic [2:0]           in_ready_o,
  output logic                 add_iv_o,
  output logic [3*WIDTH-1:0]   add_id_o,
  input  logic                 add_ov_i,
  input  logic [WIDTH-1:0]     add_od_i,
  output logic                 out_valid_o,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [IDX_W-1:0]     out_idx_o,
  input  logic                 out_ready_i,
  output logic                 err_o
);

  localparam int CNT_W = $clog2(NUM_OUT + 1);
  localparam int ICW   = $clog2(IN_DEPTH) + 1;
  localparam int OCW   = $clog2(OUT_DEPTH) + 1;
  localparam int OW    = WIDTH + IDX_W;

  localparam logic [CNT_W-1:0] LAST      = CNT_W'(NUM_OUT - 1);
  localparam logic [CNT_W-1:0] TOTAL     = CNT_W'(NUM_OUT);
  localparam logic [OCW:0]     DEPTH_LIM = (OCW + 1)'(OUT_DEPTH);

  state_t            state;
  state_t            state_n;
  logic              run;
  logic              start_tile;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  out_cnt;
  logic [CNT_W-1:0]  acc_cnt [3];
  logic [IDX_W-1:0]  idx_cnt;
  logic [OCW-1:0]    inflight;

  logic [2:0]        in_full;
  logic [2:0]        in_empty;
  logic [2:0]        in_push;
  logic [WIDTH-1:0]  in_head [3];
  logic [ICW-1:0]    unused_in_count [3];

  logic              out_full;
  logic              out_empty;
  logic              out_pop;
  logic [OCW-1:0]    out_count;
  logic [OW-1:0]     out_word;

  logic [OCW:0]      occupancy;
  logic              credit_ok;
  logic              issue;
  logic              res_push;
  logic              err_set;

  assign run        = (state == RUN);
  assign start_tile = (state == IDLE) & start_i;

  for (genvar k = 0; k < 3; k++) begin : g_in
    // A slice stops being accepted once it has delivered its NUM_OUT psums.
    assign in_ready_o[k] = run & ~in_full[k] & (acc_cnt[k] < TOTAL);
    assign in_push[k]    = in_valid_i[k] & in_ready_o[k];

    sync_fifo #(
      .W     (WIDTH),
      .DEPTH (IN_DEPTH)
    ) u_in_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_tile),
      .push      (in_push[k]),
      .push_data (in_data_i[k*WIDTH +: WIDTH]),
      .pop       (issue),
      .pop_data  (in_head[k]),
      .full      (in_full[k]),
      .empty     (in_empty[k]),
      .count     (unused_in_count[k])
    );
  end

  // Credit counts results still in the adder pipe as already occupying output slots.
  assign occupancy = {1'b0, out_count} + {1'b0, inflight};
  assign credit_ok = (occupancy < DEPTH_LIM);
  assign issue     = run & (in_empty == 3'b000) & credit_ok;

  assign add_iv_o  = issue;
  assign add_id_o  = issue ? {in_head[2], in_head[1], in_head[0]} : '0;

  assign res_push  = add_ov_i & (inflight != '0);
  assign err_set   = add_ov_i & ((inflight == '0) | out_full);

  sync_fifo #(
    .W     (OW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_tile),
    .push      (res_push),
    .push_data ({idx_cnt, add_od_i}),
    .pop       (out_pop),
    .pop_data  (out_word),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  assign out_valid_o = ~out_empty;
  assign out_pop     = out_valid_o & out_ready_i;
  assign out_data_o  = out_empty ? '0 : out_word[WIDTH-1:0];
  assign out_idx_o   = out_empty ? '0 : out_word[OW-1:WIDTH];

  assign busy_o = (state == RUN) | (state == DRAIN);
  assign done_o = (state == DONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_i) state_n = RUN;
      RUN:     if (issue && (issue_cnt == LAST)) state_n = DRAIN;
      DRAIN:   if (out_cnt == TOTAL) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      out_cnt   <= '0;
      idx_cnt   <= '0;
      inflight  <= '0;
      err_o     <= 1'b0;
      for (int k = 0; k < 3; k++) acc_cnt[k] <= '0;
    end else begin
      state <= state_n;
      if (err_set) err_o <= 1'b1;
      if (start_tile) begin
        issue_cnt <= '0;
        out_cnt   <= '0;
        idx_cnt   <= '0;
        inflight  <= '0;
        for (int k = 0; k < 3; k++) acc_cnt[k] <= '0;
      end else begin
        if (issue)    issue_cnt <= issue_cnt + CNT_W'(1);
        if (out_pop)  out_cnt   <= out_cnt + CNT_W'(1);
        if (res_push) idx_cnt   <= idx_cnt + IDX_W'(1);
        case ({issue, res_push})
          2'b10:   inflight <= inflight + OCW'(1);
          2'b01:   inflight <= inflight - OCW'(1);
          default: inflight <= inflight;
        endcase
        for (int k = 0; k < 3; k++) begin
          if (in_push[k]) acc_cnt[k] <= acc_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_psum_reduce_sched.sv
// tb/tb_psum_reduce_sched.sv - directed bench for psum_reduce_sched with a two-stage adder model
module tb_psum_reduce_sched;

  localparam int W  = 19;
  localparam int NO = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic [2:0]      in_valid = '0;
  logic [3*W-1:0]  in_data = '0;
  logic [2:0]      in_ready;
  logic            add_iv;
  logic [3*W-1:0]  add_id;
  logic            add_ov;
  logic [W-1:0]    add_od;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [IW-1:0]   out_idx;
  logic            out_ready = 1'b1;
  logic            err;

  always #5 clk = ~clk;

  psum_reduce_sched #(
    .WIDTH     (W),
    .IN_DEPTH  (4),
    .OUT_DEPTH (4),
    .NUM_OUT   (NO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .busy_o      (busy),
    .done_o      (done),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .add_iv_o    (add_iv),
    .add_id_o    (add_id),
    .add_ov_i    (add_ov),
    .add_od_i    (add_od),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_ready_i (out_ready),
    .err_o       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Adder model: result appears two cycles after the issue strobe.
  logic         s1_v, s2_v, inj = 1'b0;
  logic [W-1:0] s1_d, s2_d, sum_now;
  assign sum_now = add_id[W-1:0] + add_id[2*W-1:W] + add_id[3*W-1:2*W];
  assign add_ov  = s2_v | inj;
  assign add_od  = s2_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
    end else begin
      s1_v <= add_iv; s1_d <= sum_now;
      s2_v <= s1_v;   s2_d <= s1_d;
    end
  end

  logic [W-1:0]  q0[$], q1[$], q2[$];
  logic [W-1:0]  got_d[$];
  logic [IW-1:0] got_i[$];
  int hold[3];
  int cyc, iss_total, done_cnt, first_iss, first_ov;
  int first_push[3];

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [W-1:0] qfront(input int k);
    case (k)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic qpop(input int k);
    case (k)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  // Slice drivers change at the falling edge; handshakes are observed 4ns later.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      if (hold[k] > 0) begin
        hold[k]--;
        in_valid[k] = 1'b0;
        in_data[k*W +: W] = '0;
      end else if (qsize(k) > 0) begin
        in_valid[k] = 1'b1;
        in_data[k*W +: W] = qfront(k);
      end else begin
        in_valid[k] = 1'b0;
        in_data[k*W +: W] = '0;
      end
    end
    #4;
    for (int k = 0; k < 3; k++) begin
      if (in_valid[k] && in_ready[k]) begin
        if (first_push[k] < 0) first_push[k] = cyc;
        qpop(k);
      end
    end
    if (add_iv) begin
      iss_total++;
      if (first_iss < 0) first_iss = cyc;
    end
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_i.push_back(out_idx);
      if (first_ov < 0) first_ov = cyc;
    end
    if (done) done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  task automatic clear_mon();
    iss_total = 0; done_cnt = 0; first_iss = -1; first_ov = -1;
    for (int k = 0; k < 3; k++) first_push[k] = -1;
    got_d.delete(); got_i.delete();
  endtask

  task automatic push_trip(input int a, input int b, input int c);
    q0.push_back(W'(a)); q1.push_back(W'(b)); q2.push_back(W'(c));
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && done_cnt == 0; i++) tick();
    repeat (3) tick();
  endtask

  task automatic expect_outs(input string tag, input int e0, input int e1, input int e2, input int e3);
    logic [W-1:0] ev [4];
    logic [IW-1:0] ei;
    ev[0] = W'(e0); ev[1] = W'(e1); ev[2] = W'(e2); ev[3] = W'(e3);
    chk($sformatf("%s_count", tag), got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) begin
      ei = IW'(i);
      chk($sformatf("%s_data%0d", tag, i), got_d[i], ev[i]);
      chk($sformatf("%s_idx%0d", tag, i), got_i[i], ei);
    end
  endtask

  initial begin
    clear_mon();
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_add_iv", add_iv, 0);
    chk("rst_add_id", |add_id, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    // All slices aligned, plus one surplus psum on slice 0 that must be refused
    clear_mon();
    push_trip(1, 2, 3); push_trip(-5, 5, 7); push_trip(100, -1, 0); push_trip(-3, -3, -3);
    q0.push_back(W'(77));
    pulse_start();
    wait_done();
    expect_outs("t1", 6, 7, 99, -9);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_issue_lat", first_iss - first_push[0], 1);
    chk("t1_out_lat", first_ov - first_push[0], 4);
    chk("t1_surplus_left", qsize(0), 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_err", err, 0);
    q0.delete();
    tick();

    // Slice 2 arrives 8 cycles late
    clear_mon();
    push_trip(1, 2, 3); push_trip(-5, 5, 7); push_trip(100, -1, 0); push_trip(-3, -3, -3);
    hold[2] = 8;
    pulse_start();
    wait_done();
    expect_outs("t2", 6, 7, 99, -9);
    chk("t2_skew", first_push[2] - first_push[0], 8);
    chk("t2_first_issue", first_iss, first_push[2] + 1);
    chk("t2_done_once", done_cnt, 1);

    // Downstream stalled for 20 cycles
    clear_mon();
    out_ready = 1'b0;
    push_trip(10, 20, 30); push_trip(1, 1, 1); push_trip(-7, 0, 0); push_trip(5, -5, 5);
    pulse_start();
    repeat (20) tick();
    chk("t3_issues", iss_total, 4);
    chk("t3_no_pop", got_d.size(), 0);
    chk("t3_valid", out_valid, 1);
    chk("t3_head", out_data, 60);
    chk("t3_head_idx", out_idx, 0);
    chk("t3_busy", busy, 1);
    tick();
    chk("t3_head_stable", out_data, 60);
    chk("t3_err", err, 0);
    out_ready = 1'b1;
    wait_done();
    expect_outs("t3", 60, 3, -7, 5);
    chk("t3_err_end", err, 0);

    // Sum wraps at 19 bits
    clear_mon();
    push_trip(262143, 1, 0); push_trip(1, 2, 3); push_trip(0, 0, 0); push_trip(-1, -1, -1);
    pulse_start();
    wait_done();
    expect_outs("t4", -262144, 6, 0, -3);
    chk("t4_wrap_bits", got_d.size() > 0 ? got_d[0] : '0, 32'h40000);

    // Reset after two issues, then a clean tile
    clear_mon();
    push_trip(1, 2, 3); push_trip(-5, 5, 7); push_trip(100, -1, 0); push_trip(-3, -3, -3);
    pulse_start();
    for (int i = 0; i < 50 && iss_total < 2; i++) tick();
    chk("t5_two_issues", iss_total, 2);
    rst = 1'b1;
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) hold[k] = 0;
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_add_iv", add_iv, 0);
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_idx", out_idx, 0);
    rst = 1'b0;
    tick();
    clear_mon();
    push_trip(1, 2, 3); push_trip(-5, 5, 7); push_trip(100, -1, 0); push_trip(-3, -3, -3);
    pulse_start();
    wait_done();
    expect_outs("t5", 6, 7, 99, -9);
    chk("t5_done_once", done_cnt, 1);

    // Spurious adder result in IDLE, then start_i during RUN
    inj = 1'b1;
    tick();
    inj = 1'b0;
    tick();
    chk("t6_err_set", err, 1);
    chk("t6_no_output", out_valid, 0);
    clear_mon();
    push_trip(10, 20, 30); push_trip(1, 1, 1); push_trip(-7, 0, 0); push_trip(5, -5, 5);
    pulse_start();
    tick();
    chk("t6_busy", busy, 1);
    pulse_start();
    wait_done();
    expect_outs("t6", 60, 3, -7, 5);
    chk("t6_done_once", done_cnt, 1);
    chk("t6_idle_after", busy, 0);
    chk("t6_err_sticky", err, 1);
    rst = 1'b1;
    tick();
    chk("t6_err_cleared", err, 0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
